// File: rtl/gate8_scheduler_if.sv
// ---------------------------------------------------------------------------
// gate8_scheduler_if
// Request/response bundle between client blocks and the shared 8-bit gate
// scheduler.
//   req_valid/req_ready : per-requester handshake (N_REQ = 2**ID_W lanes)
//   req_op/req_a/req_b  : per-requester opcode and operands, packed by lane
//   rsp_valid/rsp_ready : single response handshake
//   rsp_id/rsp_data     : owning requester index and result
//   busy                : scheduler is executing or holding a response
// Modports: master = client side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface gate8_scheduler_if #(
  parameter int ID_W = 2,
  parameter int W    = 8
);
  localparam int N_REQ = 2 ** ID_W;

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [2*N_REQ-1:0] req_op;
  logic [W*N_REQ-1:0] req_a;
  logic [W*N_REQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [W-1:0]       rsp_data;
  logic               busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/gate8_scheduler.sv
// ---------------------------------------------------------------------------
// gate8_scheduler
// Arbitrates N_REQ requesters onto one bitwise AND/OR/XOR/NOT unit, executes
// one operation at a time and returns the result tagged with the requester
// index.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : gate8_scheduler_if.slave (request lanes, response channel, busy)
// Build option:
//   GATE8_SCHED_PRIO_EN defined -> fixed priority (lowest index wins).
//   undefined (default)         -> round-robin starting after last grant.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for any req_valid; grant is combinational, latch on edge
// EXEC  | evaluate latched op, register result/id, update ptr
// RESP  | rsp_valid held until rsp_ready, then back to IDLE
// ---------------------------------------------------------------------------
module gate8_scheduler #(
  parameter int ID_W = 2,
  parameter int W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  gate8_scheduler_if.slave    bus
);
  localparam int N_REQ = 2 ** ID_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_gid;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [W-1:0]    r_rsp_data;
  logic            r_busy;

  logic            w_any;
  logic [ID_W-1:0] w_grant;
  logic [ID_W-1:0] w_idx;
  logic [N_REQ-1:0] w_ready;
  logic [1:0]      w_op;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [W-1:0]    w_result;

  // Grant search. Round-robin starts one past the last served requester and
  // wraps naturally through the ID_W-bit adder; k = N_REQ lands on ptr itself
  // so a lone requester can always be served again.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
`ifdef GATE8_SCHED_PRIO_EN
      w_idx = ID_W'(k - 1);
`else
      w_idx = r_ptr + ID_W'(k);
`endif
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Payload mux for the granted lane.
  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_op = bus.req_op[2*i +: 2];
        w_a  = bus.req_a[W*i +: W];
        w_b  = bus.req_b[W*i +: W];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && w_any) begin
      w_ready[w_grant] = 1'b1;
    end
  end

  // Shared gate datapath: purely bitwise, no carries.
  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = r_a & r_b;
      2'b01:   w_result = r_a | r_b;
      2'b10:   w_result = r_a ^ r_b;
      default: w_result = ~r_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= ID_W'(N_REQ - 1);
      r_gid       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op    <= w_op;
            r_a     <= w_a;
            r_b     <= w_b;
            r_gid   <= w_grant;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= w_result;
          r_rsp_id    <= r_gid;
          r_ptr       <= r_gid;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = r_busy;

endmodule

// File: doc/gate8_scheduler.md
# gate8_scheduler

Shares a single 8-bit bitwise logic unit (AND/OR/XOR/NOT lanes built from the gate library) among several requesters. Each requester submits an opcode and two operands over a valid/ready handshake. The block arbitrates, executes one operation at a time, and returns the result tagged with the requester ID over a valid/ready response channel. It sits between client blocks and the shared gate datapath, so no client drives the gates directly.

## Interface
- `ID_W`, 2: requester ID width; the requester count is N_REQ = 2**ID_W.
- `W`, 8: operand and result width.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high.
- `req_op`  in  2*N_REQ  opcode, slice i = [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored).
- `req_a`  in  W*N_REQ  operand a, slice i = [W*i+W-1:W*i].
- `req_b`  in  W*N_REQ  operand b, same slicing as `req_a`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  ID_W  index of the requester that owns the result.
- `rsp_data`  out  W  result.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, pick grant g: the first requester with valid high, scanning from ptr+1 upward and wrapping modulo N_REQ.
  - `req_ready[g]` is combinational and asserted in this cycle.
  - On the clock edge: latch op, a and b from slice g and g into internal registers; go to EXEC.
  - If no `req_valid` is high, stay in IDLE.
- EXEC: evaluate the latched op on the gate datapath; register the result into `rsp_data` and g into `rsp_id`; set ptr = g; go to RESP.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_data` and `rsp_id` are held stable until `rsp_valid && rsp_ready`; then return to IDLE.
  - `req_ready` is all-zero.
- Requesters must hold valid and payload stable until ready. A valid that drops in IDLE before it is granted is legal and has no effect.
- NOT ignores b. No carries; every op is purely bitwise over all W bits.
- Back-to-back: a requester whose valid stays high after acceptance is served again only after every other valid requester has had a turn (round-robin).

## Timing
- Reset (async, immediate) values:
  - state = IDLE, ptr = N_REQ-1, so requester 0 wins first.
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `busy` = 0.
- Latency: accept on edge T; `rsp_valid` is high from T+2.
- Minimum issue interval is 3 cycles when `rsp_ready` is tied high.
- `rsp_ready` high while `rsp_valid` is low: ignored.
- A new request arriving during EXEC or RESP waits; it is considered at the first IDLE cycle.
- Reset mid-operation: the in-flight request is discarded and `rsp_valid` drops asynchronously. No response is ever produced for it.
- All outputs except `req_ready` are registered.

## Configuration
- `GATE8_SCHED_PRIO_EN` defined: fixed priority. Scan always starts at index 0, so the lowest index wins; ptr is still updated but is unused for arbitration.
- Not defined (default): round-robin as described in Operation.

## Test plan
- Reset, then req 0 sends OR a=0x33, b=0xCC.
  - `req_ready[0]` is high in the first cycle.
  - Two edges later: `rsp_valid` = 1, `rsp_data` = 0xFF, `rsp_id` = 0.
- Req 1 sends OR 0xAA,0xF0 → 0xFA; then XOR → 0x5A; AND → 0xA0; NOT a=0x33 (b=0x55) → 0xCC. Each result is tagged `rsp_id` = 1.
- All four requesters hold valid with `rsp_ready` = 1 → grants in order 0,1,2,3,0. With `GATE8_SCHED_PRIO_EN` defined, the grants are 0,0,0…
- `rsp_ready` held low for 5 cycles in RESP → `rsp_valid`, `rsp_data` and `rsp_id` stay constant, `req_ready` stays 0, and req 2's pending valid is not accepted. It is granted in the first IDLE cycle after the handshake.
- `rst_n` asserted during EXEC → outputs return to their reset values immediately and no `rsp_valid` ever appears for that request. After release, req 0 is granted first.
- Req 3 raises valid for 1 cycle while in RESP and then drops it → that request is never accepted and no response is tagged `rsp_id` = 3.
